// File: rtl/mc_ctrl_ws_if.sv
`default_nettype none
// ============================================================================
// mc_ctrl_ws_if : IR/flag inputs and datapath controls of the mc_ctrl_ws unit
// Rev 1.0
// ============================================================================
interface mc_ctrl_ws_if #(
  parameter int ALUOP_W = 4
);
  logic               i_zero;
  logic [5:0]         i_op;
  logic [5:0]         i_func;
  logic               i_mem_ready;
  logic               o_mem_req;
  logic               o_pc_wr;
  logic               o_ir_wr;
  logic               o_rf_wr;
  logic               o_dm_wr;
  logic [1:0]         o_ext_sel;
  logic [ALUOP_W-1:0] o_alu_op;
  logic [1:0]         o_npc_op;
  logic [1:0]         o_reg_sel;
  logic [1:0]         o_wd_sel;
  logic               o_b_sel;
  logic [3:0]         o_state;
  logic               o_bad_op;
  logic               o_mem_fault;

  // controller side
  modport master (
    input  i_zero, i_op, i_func, i_mem_ready,
    output o_mem_req, o_pc_wr, o_ir_wr, o_rf_wr, o_dm_wr, o_ext_sel, o_alu_op,
           o_npc_op, o_reg_sel, o_wd_sel, o_b_sel, o_state, o_bad_op, o_mem_fault
  );

  // datapath side
  modport slave (
    output i_zero, i_op, i_func, i_mem_ready,
    input  o_mem_req, o_pc_wr, o_ir_wr, o_rf_wr, o_dm_wr, o_ext_sel, o_alu_op,
           o_npc_op, o_reg_sel, o_wd_sel, o_b_sel, o_state, o_bad_op, o_mem_fault
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// mc_ctrl_ws : multi-cycle MIPS control unit with memory wait-state timeout
// Optional jr support: define MC_CTRL_JR_EN.                      Rev 1.0
// ============================================================================
module mc_ctrl_ws #(
  parameter int ALUOP_W     = 4,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input wire           clk,
  input wire           rst,
  mc_ctrl_ws_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DCD = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MEMWB = 4'd4,
    S_MW = 4'd5, S_EXE = 4'd6, S_ALUWB = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_FAULT = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_R = 6'b000000, c_OP_J = 6'b000010, c_OP_JAL = 6'b000011,
                         c_OP_BEQ = 6'b000100, c_OP_BNE = 6'b000101, c_OP_ADDI = 6'b001000,
                         c_OP_ADDIU = 6'b001001, c_OP_SLTI = 6'b001010, c_OP_ANDI = 6'b001100,
                         c_OP_ORI = 6'b001101, c_OP_XORI = 6'b001110, c_OP_LUI = 6'b001111,
                         c_OP_LW = 6'b100011, c_OP_SW = 6'b101011;
  localparam logic [3:0] c_ALU_ADDU = 4'd0, c_ALU_SUBU = 4'd1, c_ALU_ADD = 4'd2, c_ALU_SUB = 4'd3,
                         c_ALU_AND = 4'd4, c_ALU_OR = 4'd5, c_ALU_XOR = 4'd6, c_ALU_NOR = 4'd7,
                         c_ALU_SLT = 4'd8, c_ALU_SLTU = 4'd9, c_ALU_LUI = 4'd10;
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic            r_bad_op, r_mem_fault;

  logic w_is_rtype, w_is_lw, w_is_sw, w_is_br, w_is_jmp, w_is_jal, w_is_jr, w_ext_sign;
  logic w_is_ialu, w_r_ok;
  logic [3:0] w_i_alu, w_r_alu;

  logic       w_mem_req, w_pc_wr, w_ir_wr, w_rf_wr, w_dm_wr, w_b_sel;
  logic [1:0] w_ext_sel, w_npc_op, w_reg_sel, w_wd_sel;
  logic [3:0] w_alu_op;
  logic       w_waiting, w_set_bad, w_set_fault;

  assign w_is_rtype = (bus.i_op == c_OP_R);
  assign w_is_lw    = (bus.i_op == c_OP_LW);
  assign w_is_sw    = (bus.i_op == c_OP_SW);
  assign w_is_br    = (bus.i_op == c_OP_BEQ) || (bus.i_op == c_OP_BNE);
  assign w_is_jal   = (bus.i_op == c_OP_JAL);
  assign w_is_jmp   = (bus.i_op == c_OP_J) || w_is_jal;
  assign w_ext_sign = w_is_lw || w_is_sw || w_is_br || (bus.i_op == c_OP_ADDI) ||
                      (bus.i_op == c_OP_ADDIU) || (bus.i_op == c_OP_SLTI);
`ifdef MC_CTRL_JR_EN
  localparam logic [5:0] c_FN_JR = 6'b001000;
  assign w_is_jr = w_is_rtype && (bus.i_func == c_FN_JR);
`else
  assign w_is_jr = 1'b0;
`endif

  always_comb begin
    w_is_ialu = 1'b1;
    w_i_alu   = c_ALU_ADDU;
    case (bus.i_op)
      c_OP_ADDI:  w_i_alu = c_ALU_ADD;
      c_OP_ADDIU: w_i_alu = c_ALU_ADDU;
      c_OP_ANDI:  w_i_alu = c_ALU_AND;
      c_OP_ORI:   w_i_alu = c_ALU_OR;
      c_OP_XORI:  w_i_alu = c_ALU_XOR;
      c_OP_SLTI:  w_i_alu = c_ALU_SLT;
      c_OP_LUI:   w_i_alu = c_ALU_LUI;
      default:    w_is_ialu = 1'b0;
    endcase
  end

  always_comb begin
    w_r_ok  = 1'b1;
    w_r_alu = c_ALU_ADDU;
    case (bus.i_func)
      6'b100000: w_r_alu = c_ALU_ADD;
      6'b100001: w_r_alu = c_ALU_ADDU;
      6'b100010: w_r_alu = c_ALU_SUB;
      6'b100011: w_r_alu = c_ALU_SUBU;
      6'b100100: w_r_alu = c_ALU_AND;
      6'b100101: w_r_alu = c_ALU_OR;
      6'b100110: w_r_alu = c_ALU_XOR;
      6'b100111: w_r_alu = c_ALU_NOR;
      6'b101010: w_r_alu = c_ALU_SLT;
      6'b101011: w_r_alu = c_ALU_SLTU;
      default:   w_r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req = 1'b0; w_pc_wr = 1'b0; w_ir_wr = 1'b0; w_rf_wr = 1'b0; w_dm_wr = 1'b0;
    w_ext_sel = 2'd0; w_alu_op = c_ALU_ADDU; w_npc_op = 2'd0; w_reg_sel = 2'd0;
    w_wd_sel = 2'd0; w_b_sel = 1'b0;
    w_waiting = 1'b0; w_set_bad = 1'b0; w_set_fault = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_waiting = 1'b1;
        if (bus.i_mem_ready) begin
          w_pc_wr = 1'b1; w_ir_wr = 1'b1; w_state_nxt = S_DCD;
        end
      end
      S_DCD: begin
        if (w_ext_sign)                   w_ext_sel = 2'd1;
        else if (bus.i_op == c_OP_LUI)    w_ext_sel = 2'd2;
        if (w_is_jr)                      w_state_nxt = S_JMP;
        else if (w_is_rtype || w_is_ialu) w_state_nxt = S_EXE;
        else if (w_is_lw || w_is_sw)      w_state_nxt = S_MA;
        else if (w_is_br)                 w_state_nxt = S_BR;
        else if (w_is_jmp)                w_state_nxt = S_JMP;
        else begin
          w_set_bad = 1'b1; w_state_nxt = S_FETCH;
        end
      end
      S_EXE: begin
        w_b_sel  = w_is_ialu;
        w_alu_op = w_is_ialu ? w_i_alu : w_r_alu;
        if (w_is_rtype && !w_r_ok) begin
          w_set_bad = 1'b1; w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_rf_wr = 1'b1; w_reg_sel = w_is_ialu ? 2'd1 : 2'd0; w_state_nxt = S_FETCH;
      end
      S_MA: begin
        w_b_sel = 1'b1; w_state_nxt = w_is_lw ? S_MR : S_MW;
      end
      S_MR: begin
        w_mem_req = 1'b1; w_waiting = 1'b1;
        if (bus.i_mem_ready) w_state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        w_rf_wr = 1'b1; w_reg_sel = 2'd1; w_wd_sel = 2'd1; w_state_nxt = S_FETCH;
      end
      S_MW: begin
        w_mem_req = 1'b1; w_dm_wr = 1'b1; w_waiting = 1'b1;
        if (bus.i_mem_ready) w_state_nxt = S_FETCH;
      end
      S_BR: begin
        w_alu_op = c_ALU_SUBU; w_npc_op = 2'd1;
        w_pc_wr  = (bus.i_op == c_OP_BNE) ? ~bus.i_zero : bus.i_zero;
        w_state_nxt = S_FETCH;
      end
      S_JMP: begin
        w_pc_wr = 1'b1; w_npc_op = w_is_jr ? 2'd3 : 2'd2;
        if (w_is_jal) begin
          w_rf_wr = 1'b1; w_reg_sel = 2'd2; w_wd_sel = 2'd2;
        end
        w_state_nxt = S_FETCH;
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FETCH;
    endcase
    // A ready arriving on the last permitted wait still completes the access.
    if (w_waiting && !bus.i_mem_ready && (r_cnt == c_TO_LAST)) begin
      w_set_fault = 1'b1; w_state_nxt = S_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_cnt       <= '0;
      r_bad_op    <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= (w_waiting && !bus.i_mem_ready) ? r_cnt + TO_W'(1) : '0;
      r_bad_op    <= r_bad_op | w_set_bad;
      r_mem_fault <= r_mem_fault | w_set_fault;
    end
  end

  assign bus.o_mem_req   = w_mem_req & rst;
  assign bus.o_pc_wr     = w_pc_wr & rst;
  assign bus.o_ir_wr     = w_ir_wr & rst;
  assign bus.o_rf_wr     = w_rf_wr & rst;
  assign bus.o_dm_wr     = w_dm_wr & rst;
  assign bus.o_ext_sel   = w_ext_sel;
  assign bus.o_alu_op    = ALUOP_W'(w_alu_op);
  assign bus.o_npc_op    = w_npc_op;
  assign bus.o_reg_sel   = w_reg_sel;
  assign bus.o_wd_sel    = w_wd_sel;
  assign bus.o_b_sel     = w_b_sel;
  assign bus.o_state     = r_state;
  assign bus.o_bad_op    = r_bad_op;
  assign bus.o_mem_fault = r_mem_fault;
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl_ws : per-cycle scoreboard bench for mc_ctrl_ws      Rev 1.0
// ============================================================================
module tb_mc_ctrl_ws;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_ws_if #(.ALUOP_W(4)) bus ();
  mc_ctrl_ws #(.ALUOP_W(4), .TO_W(4), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [4:0] E_MREQ = 5'b10000, E_PC = 5'b01000, E_IR = 5'b00100,
                         E_RF = 5'b00010, E_DM = 5'b00001;

  typedef struct {
    logic        rstn;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [23:0] exp;
    string       tag;
  } item_t;

  item_t      q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       tb_bad = 1'b0, tb_flt = 1'b0;
  logic [5:0] cur_op = '0, cur_func = '0;
  logic       cur_zero = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rr();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs packed {state,en[5],ext,alu,npc,reg,wd,b,bad,fault}.
  task automatic push(input logic rstn, input logic rdy, input logic [3:0] st, input logic [4:0] en,
                      input logic [1:0] ext, input logic [3:0] alu, input logic [1:0] npc,
                      input logic [1:0] rs, input logic [1:0] wd, input logic b, input string tag);
    item_t it;
    it.rstn = rstn; it.rdy = rdy; it.zero = cur_zero; it.op = cur_op; it.func = cur_func;
    it.exp  = {st, (rstn ? en : 5'd0), ext, alu, npc, rs, wd, b, tb_bad, tb_flt};
    it.tag  = tag;
    q.push_back(it);
  endtask

  task automatic set_insn(input logic [5:0] op, input logic [5:0] func, input logic zero);
    cur_op = op; cur_func = func; cur_zero = zero;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) push(1, 0, 4'd0, E_MREQ, 0, 0, 0, 0, 0, 0, "fetch_wait");
    push(1, 1, 4'd0, E_MREQ | E_PC | E_IR, 0, 0, 0, 0, 0, 0, "fetch");
  endtask

  task automatic do_r(input logic [5:0] func, input logic [3:0] alu, input logic ok, input int waits);
    set_insn(6'd0, func, rr());
    fetch(waits);
    push(1, rr(), 4'd1, 0, 2'd0, 0, 0, 0, 0, 0, "dcd_r");
    push(1, rr(), 4'd6, 0, 2'd0, alu, 0, 0, 0, 0, "exe_r");
    if (ok) push(1, rr(), 4'd7, E_RF, 0, 0, 0, 2'd0, 2'd0, 0, "aluwb_r");
    else tb_bad = 1'b1;
  endtask

  task automatic do_i(input logic [5:0] op, input logic [3:0] alu, input logic [1:0] ext);
    set_insn(op, 6'($urandom), rr());
    fetch(0);
    push(1, rr(), 4'd1, 0, ext, 0, 0, 0, 0, 0, "dcd_i");
    push(1, rr(), 4'd6, 0, 0, alu, 0, 0, 0, 1, "exe_i");
    push(1, rr(), 4'd7, E_RF, 0, 0, 0, 2'd1, 2'd0, 0, "aluwb_i");
  endtask

  task automatic do_mem(input logic lw, input int waits);
    set_insn(lw ? 6'b100011 : 6'b101011, 6'($urandom), rr());
    fetch(0);
    push(1, rr(), 4'd1, 0, 2'd1, 0, 0, 0, 0, 0, "dcd_mem");
    push(1, rr(), 4'd2, 0, 0, 4'd0, 0, 0, 0, 1, "ma");
    for (int i = 0; i <= waits; i++)
      push(1, (i == waits), lw ? 4'd3 : 4'd5, lw ? E_MREQ : (E_MREQ | E_DM), 0, 0, 0, 0, 0, 0,
           lw ? "mr" : "mw");
    if (lw) push(1, rr(), 4'd4, E_RF, 0, 0, 0, 2'd1, 2'd1, 0, "memwb");
  endtask

  task automatic do_br(input logic bne, input logic zero);
    set_insn(bne ? 6'b000101 : 6'b000100, 6'($urandom), zero);
    fetch(0);
    push(1, rr(), 4'd1, 0, 2'd1, 0, 0, 0, 0, 0, "dcd_br");
    push(1, rr(), 4'd8, ((bne ? !zero : zero) ? E_PC : 5'd0), 0, 4'd1, 2'd1, 0, 0, 0, "br");
  endtask

  task automatic do_j(input logic jal);
    set_insn(jal ? 6'b000011 : 6'b000010, 6'($urandom), rr());
    fetch(0);
    push(1, rr(), 4'd1, 0, 2'd0, 0, 0, 0, 0, 0, "dcd_j");
    push(1, rr(), 4'd9, E_PC | (jal ? E_RF : 5'd0), 0, 0, 2'd2, jal ? 2'd2 : 2'd0,
         jal ? 2'd2 : 2'd0, 0, "jmp");
  endtask

  task automatic do_jr();
`ifdef MC_CTRL_JR_EN
    set_insn(6'd0, 6'b001000, rr());
    fetch(0);
    push(1, rr(), 4'd1, 0, 2'd0, 0, 0, 0, 0, 0, "dcd_jr");
    push(1, rr(), 4'd9, E_PC, 0, 0, 2'd3, 0, 0, 0, "jmp_jr");
`else
    do_r(6'b001000, 4'd0, 1'b0, 0);
`endif
  endtask

  initial begin
    // Reset with ready tied high, then the first fetch.
    set_insn(6'd0, 6'b100001, 1'b0);
    push(0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0, "rst_hold");
    do_r(6'b100001, 4'd0, 1'b1, 0);
    do_r(6'b100011, 4'd1, 1'b1, 1);
    do_r(6'b100111, 4'd7, 1'b1, 0);
    do_r(6'b101011, 4'd9, 1'b1, 2);
    do_i(6'b001000, 4'd2, 2'd1);
    do_i(6'b001101, 4'd5, 2'd0);
    do_i(6'b001111, 4'd10, 2'd2);
    do_i(6'b001010, 4'd8, 2'd1);
    do_mem(1'b1, 3);
    do_mem(1'b0, 2);
    do_br(1'b1, 1'b1);
    do_br(1'b1, 1'b0);
    do_br(1'b0, 1'b1);
    do_br(1'b0, 1'b0);
    do_j(1'b0);
    do_j(1'b1);
    do_jr();
    // Unsupported opcode.
    set_insn(6'b111111, 6'd0, 1'b0);
    fetch(0);
    push(1, rr(), 4'd1, 0, 2'd0, 0, 0, 0, 0, 0, "dcd_bad");
    tb_bad = 1'b1;
    do_r(6'b111111, 4'd0, 1'b0, 0);
    // Ready on the last permitted wait completes the fetch.
    do_r(6'b100100, 4'd4, 1'b1, 14);
    // Reset in the middle of a load wait.
    set_insn(6'b100011, 6'd0, 1'b0);
    fetch(0);
    push(1, 0, 4'd1, 0, 2'd1, 0, 0, 0, 0, 0, "dcd_lw2");
    push(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 1, "ma2");
    push(1, 0, 4'd3, E_MREQ, 0, 0, 0, 0, 0, 0, "mr2");
    push(0, 0, 4'd3, E_MREQ, 0, 0, 0, 0, 0, 0, "rst_mr");
    tb_bad = 1'b0;
    // Fetch timeout after 15 waits, absorbing FAULT, reset recovery.
    set_insn(6'd0, 6'b100001, 1'b0);
    for (int i = 0; i < 15; i++) push(1, 0, 4'd0, E_MREQ, 0, 0, 0, 0, 0, 0, "to_wait");
    tb_flt = 1'b1;
    for (int i = 0; i < 3; i++) push(1, 1, 4'd15, 0, 0, 0, 0, 0, 0, 0, "fault_hold");
    push(0, 1, 4'd15, 0, 0, 0, 0, 0, 0, 0, "rst_fault");
    tb_flt = 1'b0;
    do_r(6'b100110, 4'd6, 1'b1, 0);

    // Drain the scoreboard one clock per entry.
    rst = 1'b0;
    bus.i_mem_ready = 1'b1; bus.i_zero = 1'b0; bus.i_op = '0; bus.i_func = '0;
    @(posedge clk); #1;
    while (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      rst = it.rstn; bus.i_mem_ready = it.rdy; bus.i_zero = it.zero;
      bus.i_op = it.op; bus.i_func = it.func;
      @(negedge clk);
      check(it.tag, {8'd0, bus.o_state, bus.o_mem_req, bus.o_pc_wr, bus.o_ir_wr, bus.o_rf_wr,
                     bus.o_dm_wr, bus.o_ext_sel, bus.o_alu_op, bus.o_npc_op, bus.o_reg_sel,
                     bus.o_wd_sel, bus.o_b_sel, bus.o_bad_op, bus.o_mem_fault},
            {8'd0, it.exp});
      @(posedge clk); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
